// File: rtl/neander_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package neander_mem_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] FLASH_BASE_DEFAULT = 16'hC000;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Unsigned region decode: at or above the base is Flash.
  function automatic logic is_flash(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1 with wrap.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = {N{1'b0}};
    idx   = {IDW{1'b0}};
    cand  = {IDW{1'b0}};
    for (int i = N; i >= 1; i--) begin
      cand = IDW'((int'(last) + i) % N);
      if (req[cand]) begin
        idx   = cand;
        grant = {{(N-1){1'b0}}, 1'b1} << cand;
      end else begin
        idx   = idx;
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory controller between several
// masters, with RAM/Flash decode, Flash write rejection and a watchdog.
module spi_mem_arbiter
  import neander_mem_pkg::*;
#(
  parameter int                NUM_REQ        = 2,
  parameter logic [ADDR_W-1:0] FLASH_BASE     = FLASH_BASE_DEFAULT,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ-1:0]                          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]                   req_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]                   req_wdata,
  output logic [NUM_REQ-1:0]                          req_ready,
  output logic                                        req_err,
  output logic [ADDR_W-1:0]                           rsp_rdata,
  output logic                                        m_req,
  output logic                                        m_we,
  output logic [ADDR_W-1:0]                           m_addr,
  output logic [ADDR_W-1:0]                           m_wdata,
  output logic                                        m_cs_select,
  input  logic [ADDR_W-1:0]                           m_rdata,
  input  logic                                        m_ready,
  input  logic                                        m_busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                        active
);

  localparam int         IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_CYCLES);
  localparam logic       TO_ENABLE = (TIMEOUT_CYCLES != 0);

  arb_state_t        state_r, state_s;
  logic [IDW-1:0]    last_grant_r, last_s, grant_s;
  logic [7:0]        wdog_r, wdog_s, wdog_inc_s;
  logic              we_s, cs_s, err_s;
  logic [ADDR_W-1:0] addr_s, wdata_s, rdata_s;
  logic [NUM_REQ-1:0] ready_s, win_onehot_s;
  logic [IDW-1:0]    win_idx_s;
  logic [ADDR_W-1:0] win_addr_s, win_wdata_s;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .last  (last_grant_r),
    .grant (win_onehot_s),
    .idx   (win_idx_s)
  );

  // Select the winning port's address and write data from the packed buses.
  always_comb begin
    win_addr_s  = req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
    win_wdata_s = req_wdata[int'(win_idx_s)*ADDR_W +: ADDR_W];
    wdog_inc_s  = wdog_r + 8'd1;
  end

  // The controller request is a one-cycle strobe issued as soon as it is idle.
  assign m_req  = (state_r == ST_ISSUE) && !m_busy;
  assign active = (state_r != ST_IDLE);

  // Next-state and next-register values for the transaction sequencer.
  always_comb begin
    state_s = state_r;
    grant_s = grant_id;
    last_s  = last_grant_r;
    we_s    = m_we;
    addr_s  = m_addr;
    wdata_s = m_wdata;
    cs_s    = m_cs_select;
    ready_s = {NUM_REQ{1'b0}};
    err_s   = req_err;
    rdata_s = rsp_rdata;
    wdog_s  = wdog_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_s = win_idx_s;
          last_s  = win_idx_s;
          we_s    = req_we[win_idx_s];
          addr_s  = win_addr_s;
          wdata_s = win_wdata_s;
          cs_s    = is_flash(win_addr_s, FLASH_BASE);
          if (req_we[win_idx_s] && cs_s) begin
            // Flash is read-only here: answer with an error, no bus access.
            state_s = ST_RESP;
            err_s   = 1'b1;
            rdata_s = {ADDR_W{1'b0}};
            ready_s = win_onehot_s;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Any m_ready seen here belongs to an aborted access and is ignored.
        if (!m_busy) begin
          state_s = ST_WAIT;
          wdog_s  = 8'd0;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (m_ready) begin
          state_s = ST_RESP;
          err_s   = 1'b0;
          rdata_s = m_we ? {ADDR_W{1'b0}} : m_rdata;
          ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        end else if (TO_ENABLE && (wdog_inc_s == TO_LIMIT)) begin
          state_s = ST_RESP;
          err_s   = 1'b1;
          rdata_s = {ADDR_W{1'b0}};
          ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        end else begin
          wdog_s  = wdog_inc_s;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDW'(NUM_REQ - 1);
      grant_id     <= {IDW{1'b0}};
      wdog_r       <= 8'd0;
      m_we         <= 1'b0;
      m_addr       <= {ADDR_W{1'b0}};
      m_wdata      <= {ADDR_W{1'b0}};
      m_cs_select  <= 1'b0;
      req_ready    <= {NUM_REQ{1'b0}};
      req_err      <= 1'b0;
      rsp_rdata    <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_s;
      grant_id     <= grant_s;
      wdog_r       <= wdog_s;
      m_we         <= we_s;
      m_addr       <= addr_s;
      m_wdata      <= wdata_s;
      m_cs_select  <= cs_s;
      req_ready    <= ready_s;
      req_err      <= err_s;
      rsp_rdata    <= rdata_s;
    end
  end

endmodule
